spi_sram_target: RTL
====================

Name: spi_sram_target

Overview:
- SPI mode-0 target that emulates a 23LC1024-style serial SRAM in sequential mode, backed by an on-chip byte array.
- It is the responder for the CPU's external SRAM SPI initiator (si/so/sclk/sram_ce). Uses: on-chip loopback for bring-up, simulation benches, and an external host path into a scratchpad.
- All SPI inputs are oversampled in the clk domain. No second clock exists.

Parameters:
- DEPTH_BYTES, 256: backing store size in bytes; power of two, 16..1024.
- MODE_VAL, 8'h40: value returned by RDMR (sequential mode).

Ports:
- clk  in  1  system clock; must be at least 8x the SCLK frequency.
- reset  in  1  synchronous, active-low.
- sclk  in  1  SPI clock from initiator, idle low.
- cs_n  in  1  chip select, active-low (the initiator's sram_ce).
- si  in  1  MOSI, initiator to target.
- so  out  1  MISO, target to initiator.
- so_oe  out  1  MISO drive enable; 1 only during read data / RDMR data phases.
- active  out  1  high while a recognised command is in progress.
- wr_strobe  out  1  one-clk pulse per committed write byte.
- cmd_err  out  1  one-clk pulse when an unknown opcode completes.

Behaviour:
- Reset (reset==0 at posedge clk):
  - so=0, so_oe=0, active=0, wr_strobe=0, cmd_err=0.
  - FSM=IDLE; bit counter=0; address=0.
  - All memory bytes cleared to 8'h00.
- Synchronisers:
  - sclk, cs_n, si each pass through 2 flops; cs_n flops reset to 1.
  - rise = sclk_s & ~sclk_q; fall = ~sclk_s & sclk_q.
  - Input-to-action latency is 3 clk.
- Bit handling:
  - Sample si only on rise, MSB first.
  - Update so only on fall.
  - A 3-bit counter counts rises within a byte and wraps 7->0.
- cs_n_s==1 overrides everything, every cycle:
  - FSM=IDLE, counter=0, so_oe=0, active=0.
  - A partial byte is discarded; memory is not modified.
- FSM states: IDLE, CMD, ADDR, RD_DATA, WR_DATA, RDMR, WRMR, IGNORE.
- IDLE -> CMD when cs_n_s falls.
- CMD: after the 8th rise, decode the opcode.
  - 8'h03 READ -> ADDR, active=1.
  - 8'h02 WRITE -> ADDR, active=1.
  - 8'h05 / 8'h01 -> see Optional Feature.
  - Any other opcode -> IGNORE with a one-clk cmd_err pulse.
- ADDR: shift 24 bits; effective address = addr[log2(DEPTH_BYTES)-1:0]. Upper bits are ignored with no error.
  - READ: on the 24th rise, load the shift-out register with mem[addr] and go to RD_DATA.
  - WRITE: go to WR_DATA.
- RD_DATA:
  - so_oe=1 from the first fall after entry.
  - Each fall: so=shreg[7], shreg<<=1. The MSB is valid before the first data rise.
  - On the 8th rise of each byte: addr=addr+1 mod DEPTH_BYTES, then reload shreg with mem[new addr].
  - Continues until cs_n.
- WR_DATA: on the 8th rise of each byte:
  - mem[addr] <= byte; wr_strobe pulses exactly one clk.
  - addr=addr+1 mod DEPTH_BYTES.
- Wrap-around: the address wraps DEPTH_BYTES-1 -> 0 in both directions of transfer; no error.
- IGNORE: so_oe=0; all sclk activity is ignored until cs_n.
- Read-after-write: a byte written in one transaction is readable by the next transaction. Minimum cs_n high time is 4 clk.
- Reset mid-transaction: returns immediately to the reset state. The host must deassert cs_n before retrying.

Optional Feature:
- Macro: SPI_SRAM_TARGET_MODEREG_EN.
- Defined:
  - 8'h05 RDMR -> RDMR state; shifts out MODE_VAL with the same timing as RD_DATA, then repeats MODE_VAL each byte.
  - 8'h01 WRMR -> WRMR state; consumes one byte and discards it (mode is fixed); further bytes are ignored; active=1.
- Undefined: 8'h05 and 8'h01 are unknown opcodes -> IGNORE plus cmd_err pulse. The RDMR/WRMR states are not synthesised.

Test Plan:
- Write then read: WRITE 02,000010, data A5 3C; cs_n high; READ 03,000010, 16 clocks -> so bytes A5 3C; wr_strobe pulses exactly 2.
- Wrap: DEPTH=256, WRITE at 0000FF, data 11 22 -> mem[FF]=11, mem[00]=22; READ at 0000FF -> 11 22.
- Aborted byte: WRITE at 000020, full byte 77 then 5 bits of 0xFF, cs_n high -> mem[20]=77, mem[21]=00; 1 wr_strobe pulse.
- Unknown opcode 9F -> cmd_err one pulse after the 8th rise; so_oe stays 0; memory unchanged.
- Opcode 05: with macro -> so shifts 40 40; without macro -> cmd_err pulse, so_oe=0.
- Reset during READ data phase -> so/so_oe/active=0 on the next clk; memory reads 00 afterwards; a new READ after cs_n cycling works.

Source files
------------

// File: rtl/spi_sram_target.sv
// Purpose : SPI mode-0 target emulating a 23LC1024-style serial SRAM (sequential mode) over an on-chip byte array.
// Latency : SPI pins are 2-flop synchronised, then edge-detected; pin change to internal action is 3 clk.
// Backpressure: none; the SPI initiator sets the pace, and clk must run at least 8x SCLK.
//
// Ports:
//   clk, reset        system clock; synchronous active-low reset (also clears the memory)
//   sclk, cs_n, si    SPI inputs from the initiator (idle-low SCLK, active-low select, MOSI)
//   so, so_oe         MISO data and its drive enable (read / mode-read data phases only)
//   active            a recognised command is in progress
//   wr_strobe         one-clk pulse per committed write byte
//   cmd_err           one-clk pulse when an unknown opcode has been received
// Optional feature: define SPI_SRAM_TARGET_MODEREG_EN to add RDMR (05) / WRMR (01) handling.
module spi_sram_target #(
   parameter int         DEPTH_BYTES = 256,
   parameter logic [7:0] MODE_VAL    = 8'h40
) (
   input  logic clk,
   input  logic reset,
   input  logic sclk,
   input  logic cs_n,
   input  logic si,
   output logic so,
   output logic so_oe,
   output logic active,
   output logic wr_strobe,
   output logic cmd_err
);
   localparam int AW = $clog2(DEPTH_BYTES);
   localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_RD_DATA, S_WR_DATA, S_RDMR, S_WRMR, S_IGNORE
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    sclk_sync_q, cs_sync_q, si_sync_q;
   logic          sclk_prev_q;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [1:0]    addr_byte_q, addr_byte_d;
   logic [7:0]    sin_q, sin_d, shreg_q, shreg_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          is_read_q, is_read_d;
   logic          so_q, so_d, so_oe_q, so_oe_d, wr_strobe_q, wr_strobe_d, cmd_err_q, cmd_err_d;
   logic          mem_we;
   logic [7:0]    mem_q [DEPTH_BYTES];

   logic          sclk_s, cs_s, si_s, rise, fall, byte_done;
   logic [7:0]    sin_next;
   logic [AW-1:0] addr_shift, addr_inc;

   assign sclk_s     = sclk_sync_q[1];
   assign cs_s       = cs_sync_q[1];
   assign si_s       = si_sync_q[1];
   assign rise       = sclk_s & ~sclk_prev_q;
   assign fall       = ~sclk_s & sclk_prev_q;
   assign byte_done  = rise && (bit_cnt_q == 3'd7);
   assign sin_next   = {sin_q[6:0], si_s};
   // Address bits shift straight into an AW-wide register, so the upper
   // address bits simply fall off the top and are ignored.
   assign addr_shift = {addr_q[AW-2:0], si_s};
   assign addr_inc   = addr_q + ADDR_ONE;

   assign so        = so_q;
   assign so_oe     = so_oe_q;
   assign wr_strobe = wr_strobe_q;
   assign cmd_err   = cmd_err_q;
   assign active    = (state_q == S_ADDR) || (state_q == S_RD_DATA) || (state_q == S_WR_DATA) ||
                      (state_q == S_RDMR) || (state_q == S_WRMR);

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      addr_byte_d = addr_byte_q;
      sin_d       = sin_q;
      shreg_d     = shreg_q;
      addr_d      = addr_q;
      is_read_d   = is_read_q;
      so_d        = so_q;
      so_oe_d     = so_oe_q;
      wr_strobe_d = 1'b0;
      cmd_err_d   = 1'b0;
      mem_we      = 1'b0;

      if (rise) begin
         bit_cnt_d = bit_cnt_q + 3'd1;
         sin_d     = sin_next;
      end

      case (state_q)
         S_IDLE: begin
            bit_cnt_d = 3'd0;
            if (!cs_s) state_d = S_CMD;
         end
         S_CMD: begin
            if (byte_done) begin
               addr_byte_d = 2'd0;
               case (sin_next)
                  8'h03: begin state_d = S_ADDR; is_read_d = 1'b1; end
                  8'h02: begin state_d = S_ADDR; is_read_d = 1'b0; end
`ifdef SPI_SRAM_TARGET_MODEREG_EN
                  8'h05: begin state_d = S_RDMR; shreg_d = MODE_VAL; end
                  8'h01: state_d = S_WRMR;
`endif
                  default: begin state_d = S_IGNORE; cmd_err_d = 1'b1; end
               endcase
            end
         end
         S_ADDR: begin
            if (rise) addr_d = addr_shift;
            if (byte_done) begin
               addr_byte_d = addr_byte_q + 2'd1;
               if (addr_byte_q == 2'd2) begin
                  if (is_read_q) begin
                     shreg_d = mem_q[addr_shift];
                     state_d = S_RD_DATA;
                  end else begin
                     state_d = S_WR_DATA;
                  end
               end
            end
         end
`ifdef SPI_SRAM_TARGET_MODEREG_EN
         S_RD_DATA, S_RDMR: begin
`else
         S_RD_DATA: begin
`endif
            // so changes only on SCLK fall, so it is stable for the next rise.
            if (fall) begin
               so_d    = shreg_q[7];
               shreg_d = {shreg_q[6:0], 1'b0};
               so_oe_d = 1'b1;
            end
            if (byte_done) begin
`ifdef SPI_SRAM_TARGET_MODEREG_EN
               if (state_q == S_RDMR) begin
                  shreg_d = MODE_VAL;
               end else begin
                  addr_d  = addr_inc;
                  shreg_d = mem_q[addr_inc];
               end
`else
               addr_d  = addr_inc;
               shreg_d = mem_q[addr_inc];
`endif
            end
         end
         S_WR_DATA: begin
            if (byte_done) begin
               mem_we      = 1'b1;
               wr_strobe_d = 1'b1;
               addr_d      = addr_inc;
            end
         end
         default: so_oe_d = 1'b0;  // IGNORE, and WRMR which just swallows bytes
      endcase

      // Deselect wins over everything: any partial byte is dropped unwritten.
      if (cs_s) begin
         state_d     = S_IDLE;
         bit_cnt_d   = 3'd0;
         so_d        = 1'b0;
         so_oe_d     = 1'b0;
         wr_strobe_d = 1'b0;
         cmd_err_d   = 1'b0;
         mem_we      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sclk_sync_q <= 2'b00;
         cs_sync_q   <= 2'b11;
         si_sync_q   <= 2'b00;
         sclk_prev_q <= 1'b0;
         state_q     <= S_IDLE;
         bit_cnt_q   <= 3'd0;
         addr_byte_q <= 2'd0;
         sin_q       <= 8'h00;
         shreg_q     <= 8'h00;
         addr_q      <= '0;
         is_read_q   <= 1'b0;
         so_q        <= 1'b0;
         so_oe_q     <= 1'b0;
         wr_strobe_q <= 1'b0;
         cmd_err_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], sclk};
         cs_sync_q   <= {cs_sync_q[0], cs_n};
         si_sync_q   <= {si_sync_q[0], si};
         sclk_prev_q <= sclk_s;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         addr_byte_q <= addr_byte_d;
         sin_q       <= sin_d;
         shreg_q     <= shreg_d;
         addr_q      <= addr_d;
         is_read_q   <= is_read_d;
         so_q        <= so_d;
         so_oe_q     <= so_oe_d;
         wr_strobe_q <= wr_strobe_d;
         cmd_err_q   <= cmd_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_q <= '{default: 8'h00};
      end else if (mem_we) begin
         mem_q[addr_q] <= sin_next;
      end
   end
endmodule
